// File: rtl/dmem_lsu.sv
// LSU data memory: one load/store per cycle, 2-cycle response latency, in-order tagged responses.
// o_req_ready is state-only and reserves a FIFO slot for S1, so S1 never stalls under backpressure.
module dmem_lsu_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_vld,
    input  logic [W-1:0]  push_dat,
    output logic          pop_vld,
    input  logic          pop_rdy,
    output logic [W-1:0]  pop_dat,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop_vld = (count != '0);
    assign pop     = pop_vld & pop_rdy;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) wr_ptr <= nxt(wr_ptr);
            if (pop)      rd_ptr <= nxt(rd_ptr);
            case ({push_vld, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_vld) mem[wr_ptr] <= push_dat;
    end
endmodule

module dmem_lsu #(
    parameter int DEPTH_WORDS = 1024,
    parameter int TAG_W       = 4,
    parameter int RSP_DEPTH   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic             i_req_we,
    input  logic [1:0]       i_req_size,
    input  logic             i_req_unsigned,
    input  logic [31:0]      i_req_addr,
    input  logic [31:0]      i_req_wdata,
    input  logic [TAG_W-1:0] i_req_tag,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [31:0]      o_rsp_rdata,
    output logic [TAG_W-1:0] o_rsp_tag,
    output logic             o_rsp_err
);
    localparam int ADDR_W = $clog2(DEPTH_WORDS);
    localparam int CW     = $clog2(RSP_DEPTH + 1);

    typedef struct packed {
        logic [31:0]      rdata;
        logic [TAG_W-1:0] tag;
        logic             err;
    } rsp_t;

    logic [31:0]       mem [DEPTH_WORDS];
    logic [ADDR_W-1:0] idx;
    logic              accept;
    logic              req_err;
    logic [3:0]        be;
    logic [31:0]       wdat;

    logic              s1_vld;
    logic              s1_we;
    logic              s1_err;
    logic [1:0]        s1_size;
    logic [1:0]        s1_off;
    logic              s1_uns;
    logic [TAG_W-1:0]  s1_tag;
    logic [31:0]       s1_word;
    logic [31:0]       s1_sh;
    logic [31:0]       ld_dat;

    rsp_t              push_dat;
    rsp_t              head;
    logic [CW-1:0]     fifo_cnt;
    logic [CW:0]       occ;

    assign idx     = i_req_addr[ADDR_W+1:2];
    assign req_err = (|i_req_addr[31:ADDR_W+2])
                   | (i_req_size == 2'd3)
                   | ((i_req_size == 2'd1) & i_req_addr[0])
                   | ((i_req_size == 2'd2) & (i_req_addr[1:0] != 2'b00));

    // Counting S1 as occupied guarantees its push always finds room.
    assign occ         = (CW + 1)'(fifo_cnt) + (CW + 1)'(s1_vld);
    assign o_req_ready = rst_n & (occ < (CW + 1)'(RSP_DEPTH));
    assign accept      = i_req_valid & o_req_ready;

    always_comb begin
        be   = 4'hF;
        wdat = i_req_wdata;
        case (i_req_size)
            2'd0: begin
                be   = 4'b0001 << i_req_addr[1:0];
                wdat = {4{i_req_wdata[7:0]}};
            end
            2'd1: begin
                be   = 4'b0011 << i_req_addr[1:0];
                wdat = {2{i_req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Write and read share the accepting edge; nonblocking makes the read see old data.
    always_ff @(posedge clk) begin
        if (accept & i_req_we & ~req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wdat[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_word <= mem[idx];
            s1_we   <= i_req_we;
            s1_err  <= req_err;
            s1_size <= i_req_size;
            s1_off  <= i_req_addr[1:0];
            s1_uns  <= i_req_unsigned;
            s1_tag  <= i_req_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) s1_vld <= 1'b0;
        else        s1_vld <= accept;
    end

    always_comb begin
        s1_sh  = s1_word >> {s1_off, 3'b000};
        ld_dat = s1_sh;
        case (s1_size)
            2'd0:    ld_dat = s1_uns ? {24'd0, s1_sh[7:0]}  : {{24{s1_sh[7]}}, s1_sh[7:0]};
            2'd1:    ld_dat = s1_uns ? {16'd0, s1_sh[15:0]} : {{16{s1_sh[15]}}, s1_sh[15:0]};
            default: ;
        endcase
        if (s1_we | s1_err) ld_dat = 32'd0;
    end

    assign push_dat.rdata = ld_dat;
    assign push_dat.tag   = s1_tag;
    assign push_dat.err   = s1_err;

    dmem_lsu_fifo #(.W($bits(rsp_t)), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (s1_vld),
        .push_dat (push_dat),
        .pop_vld  (o_rsp_valid),
        .pop_rdy  (i_rsp_ready),
        .pop_dat  (head),
        .count    (fifo_cnt)
    );

    assign o_rsp_rdata = head.rdata;
    assign o_rsp_tag   = head.tag;
    assign o_rsp_err   = head.err;
endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: single-transaction vector table plus backpressure, RAW and reset sequences.
module tb_dmem_lsu;
    localparam int RSP_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic [1:0]  i_req_size;
    logic        i_req_unsigned;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic [3:0]  i_req_tag;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_rdata;
    logic [3:0]  o_rsp_tag;
    logic        o_rsp_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_lsu #(.DEPTH_WORDS(1024), .TAG_W(4), .RSP_DEPTH(RSP_DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_req_valid    (i_req_valid),
        .o_req_ready    (o_req_ready),
        .i_req_we       (i_req_we),
        .i_req_size     (i_req_size),
        .i_req_unsigned (i_req_unsigned),
        .i_req_addr     (i_req_addr),
        .i_req_wdata    (i_req_wdata),
        .i_req_tag      (i_req_tag),
        .o_rsp_valid    (o_rsp_valid),
        .i_rsp_ready    (i_rsp_ready),
        .o_rsp_rdata    (o_rsp_rdata),
        .o_rsp_tag      (o_rsp_tag),
        .o_rsp_err      (o_rsp_err)
    );

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  tag;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] tag);
        i_req_valid    = 1'b1;
        i_req_we       = we;
        i_req_size     = sz;
        i_req_unsigned = uns;
        i_req_addr     = addr;
        i_req_wdata    = wd;
        i_req_tag      = tag;
    endtask

    // One request with i_rsp_ready=1; checks latency and response fields.
    task automatic do_req(input vec_t v, input string nm);
        int n;
        @(negedge clk);
        n = 0;
        while (!o_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " ready"}, {31'd0, o_req_ready}, 32'd1);
        drive(v.we, v.size, v.uns, v.addr, v.wdata, v.tag);
        @(posedge clk);
        n = 0;
        do begin
            @(negedge clk);
            i_req_valid = 1'b0;
            n++;
        end while (!o_rsp_valid && n < 10);
        chk({nm, " latency"}, n, 32'd2);
        chk({nm, " rdata"}, o_rsp_rdata, v.exp_rdata);
        chk({nm, " tag"}, {28'd0, o_rsp_tag}, {28'd0, v.tag});
        chk({nm, " err"}, {31'd0, o_rsp_err}, {31'd0, v.exp_err});
    endtask

    logic [31:0] exp_q [16];
    int          acc;
    int          got;
    int          cyc;

    initial begin
        rst_n = 1'b0;
        i_rsp_ready = 1'b1;
        drive(1'b0, 2'd2, 1'b0, 32'd0, 32'd0, 4'd0);
        i_req_valid = 1'b0;

        //        we    size  uns   addr          wdata         tag    exp_rdata     err
        vt.push_back('{1'b1, 2'd2, 1'b0, 32'h0000_0040, 32'h1234_5678, 4'd1,  32'h0000_0000, 1'b0});
        vt.push_back('{1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'h0,         4'd3,  32'h1234_5678, 1'b0});
        vt.push_back('{1'b1, 2'd0, 1'b0, 32'h0000_0041, 32'h0000_0080, 4'd2,  32'h0000_0000, 1'b0});
        vt.push_back('{1'b0, 2'd0, 1'b0, 32'h0000_0041, 32'h0,         4'd4,  32'hFFFF_FF80, 1'b0});
        vt.push_back('{1'b0, 2'd0, 1'b1, 32'h0000_0041, 32'h0,         4'd5,  32'h0000_0080, 1'b0});
        vt.push_back('{1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'h0,         4'd6,  32'h1234_8078, 1'b0});
        vt.push_back('{1'b1, 2'd1, 1'b0, 32'h0000_0042, 32'h0000_BEEF, 4'd7,  32'h0000_0000, 1'b0});
        vt.push_back('{1'b0, 2'd1, 1'b0, 32'h0000_0042, 32'h0,         4'd8,  32'hFFFF_BEEF, 1'b0});
        vt.push_back('{1'b0, 2'd1, 1'b1, 32'h0000_0042, 32'h0,         4'd9,  32'h0000_BEEF, 1'b0});
        vt.push_back('{1'b0, 2'd0, 1'b0, 32'h0000_0043, 32'h0,         4'd10, 32'hFFFF_FFBE, 1'b0});
        vt.push_back('{1'b0, 2'd2, 1'b0, 32'h0000_0042, 32'h0,         4'd11, 32'h0000_0000, 1'b1});
        vt.push_back('{1'b1, 2'd1, 1'b0, 32'h0000_0041, 32'h0000_1234, 4'd12, 32'h0000_0000, 1'b1});
        vt.push_back('{1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0,         4'd13, 32'h0000_0000, 1'b1});
        vt.push_back('{1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'h0,         4'd14, 32'hBEEF_8078, 1'b0});
        vt.push_back('{1'b1, 2'd2, 1'b0, 32'h0000_0000, 32'hA5A5_A5A5, 4'd15, 32'h0000_0000, 1'b0});
        vt.push_back('{1'b1, 2'd2, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 4'd0,  32'h0000_0000, 1'b1});
        vt.push_back('{1'b0, 2'd2, 1'b0, 32'h0000_0000, 32'h0,         4'd1,  32'hA5A5_A5A5, 1'b0});
        vt.push_back('{1'b1, 2'd2, 1'b0, 32'h0000_0FFC, 32'h0BAD_F00D, 4'd2,  32'h0000_0000, 1'b0});
        vt.push_back('{1'b0, 2'd2, 1'b1, 32'h0000_0FFC, 32'h0,         4'd3,  32'h0BAD_F00D, 1'b0});
        vt.push_back('{1'b0, 2'd2, 1'b0, 32'h8000_0000, 32'h0,         4'd4,  32'h0000_0000, 1'b1});
        vt.push_back('{1'b1, 2'd0, 1'b0, 32'h0000_0043, 32'h0000_01FF, 4'd5,  32'h0000_0000, 1'b0});
        vt.push_back('{1'b0, 2'd0, 1'b1, 32'h0000_0043, 32'h0,         4'd6,  32'h0000_00FF, 1'b0});
        vt.push_back('{1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'h0,         4'd7,  32'hFFEF_8078, 1'b0});
        vt.push_back('{1'b0, 2'd1, 1'b0, 32'h0000_0040, 32'h0,         4'd8,  32'hFFFF_8078, 1'b0});
        vt.push_back('{1'b1, 2'd3, 1'b0, 32'h0000_0000, 32'h0,         4'd9,  32'h0000_0000, 1'b1});
        vt.push_back('{1'b0, 2'd2, 1'b0, 32'h0000_0000, 32'h0,         4'd10, 32'hA5A5_A5A5, 1'b0});

        repeat (3) @(negedge clk);
        chk("reset ready", {31'd0, o_req_ready}, 32'd0);
        chk("reset valid", {31'd0, o_rsp_valid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset ready", {31'd0, o_req_ready}, 32'd1);

        foreach (vt[i]) do_req(vt[i], $sformatf("vec%0d", i));

        // Backpressure: FIFO plus S1 fill after RSP_DEPTH accepts.
        @(negedge clk);
        i_rsp_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            logic will;
            drive(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, acc[3:0]);
            will = o_req_ready;
            @(posedge clk);
            if (will) acc++;
            @(negedge clk);
        end
        i_req_valid = 1'b0;
        chk("bp accepts", acc, RSP_DEPTH);
        chk("bp ready low", {31'd0, o_req_ready}, 32'd0);
        i_rsp_ready = 1'b1;
        for (int k = 0; k < RSP_DEPTH; k++) begin
            chk($sformatf("bp valid%0d", k), {31'd0, o_rsp_valid}, 32'd1);
            chk($sformatf("bp tag%0d", k), {28'd0, o_rsp_tag}, k);
            chk($sformatf("bp rdata%0d", k), o_rsp_rdata, 32'hFFEF_8078);
            @(negedge clk);
        end
        chk("bp drained", {31'd0, o_rsp_valid}, 32'd0);

        // Sustained stream, alternating store/load on one word: back-to-back RAW.
        for (int i = 0; i < 8; i++)
            exp_q[i] = (i % 2 == 0) ? 32'd0 : (i - 1) * 32'h1111_1111;
        got = 0;
        cyc = 0;
        for (int i = 0; i < 14 && got < 8; i++) begin
            if (i < 8) begin
                chk($sformatf("stream ready%0d", i), {31'd0, o_req_ready}, 32'd1);
                drive((i % 2) == 0, 2'd2, 1'b0, 32'h200, i * 32'h1111_1111, 4'(i));
            end else begin
                i_req_valid = 1'b0;
            end
            if (o_rsp_valid) begin
                chk($sformatf("stream tag%0d", got), {28'd0, o_rsp_tag}, got);
                chk($sformatf("stream rdata%0d", got), o_rsp_rdata, exp_q[got]);
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        i_req_valid = 1'b0;
        chk("stream count", got, 32'd8);
        chk("stream cycles", cyc, 32'd10);

        // Reset with a store and a load in flight.
        @(negedge clk);
        i_rsp_ready = 1'b0;
        drive(1'b1, 2'd2, 1'b0, 32'h300, 32'h0000_0077, 4'd1);
        @(negedge clk);
        drive(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 4'd2);
        @(negedge clk);
        i_req_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid reset ready", {31'd0, o_req_ready}, 32'd0);
        chk("mid reset valid", {31'd0, o_rsp_valid}, 32'd0);
        rst_n = 1'b1;
        i_rsp_ready = 1'b1;
        @(negedge clk);
        chk("rst release ready", {31'd0, o_req_ready}, 32'd1);
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            if (o_rsp_valid) acc++;
            @(negedge clk);
        end
        chk("no rsp after reset", acc, 32'd0);
        do_req('{1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 4'd6, 32'h0000_0077, 1'b0}, "store survives reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, total=%0d", total);
        $fatal(1);
    end
endmodule
